// File: rtl/slipstream_scheduler.sv
// Sequences obstruction angles into the slipstream processor, captures its fan
// demands and slews six fan duty outputs toward them; re-captures on idle timeout.
module slipstream_scheduler #(
    parameter int RAMP_STEP     = 5,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_angle_valid,
    input  logic [8:0] i_angle,
    output logic       o_angle_ready,
    output logic [8:0] o_proc_angle,
    input  logic [6:0] i_proc_fan_1,
    input  logic [6:0] i_proc_fan_2,
    input  logic [6:0] i_proc_fan_3,
    input  logic [6:0] i_proc_fan_4,
    input  logic [6:0] i_proc_fan_5,
    input  logic [6:0] i_proc_fan_6,
    output logic [6:0] o_fan_1,
    output logic [6:0] o_fan_2,
    output logic [6:0] o_fan_3,
    output logic [6:0] o_fan_4,
    output logic [6:0] o_fan_5,
    output logic [6:0] o_fan_6,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, RAMP} state_t;

    localparam logic [8:0]        NO_OBST     = 9'd360;
    localparam logic [15:0]       TIMEOUT_LIM = 16'(TIMEOUT_TICKS);
    localparam logic signed [7:0] STEP        = 8'(RAMP_STEP);

    function automatic logic [6:0] clamp_pct(input logic [6:0] v);
        return (v > 7'd100) ? 7'd100 : v;
    endfunction

    // Both operands are 0..100, so a signed 8-bit difference never wraps.
    function automatic logic [6:0] ramp_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic signed [7:0] diff;
        logic signed [7:0] nxt;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP)
            nxt = $signed({1'b0, cur}) + STEP;
        else if (diff < -STEP)
            nxt = $signed({1'b0, cur}) - STEP;
        else
            nxt = $signed({1'b0, tgt});
        return nxt[6:0];
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [8:0]  angle_q, angle_d;
    logic [6:0]  fan_q [6];
    logic [6:0]  fan_d [6];
    logic [6:0]  tgt_q [6];
    logic [6:0]  tgt_d [6];
    logic [6:0]  proc_fan [6];
    logic        all_eq;

    assign proc_fan[0] = i_proc_fan_1;
    assign proc_fan[1] = i_proc_fan_2;
    assign proc_fan[2] = i_proc_fan_3;
    assign proc_fan[3] = i_proc_fan_4;
    assign proc_fan[4] = i_proc_fan_5;
    assign proc_fan[5] = i_proc_fan_6;

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (fan_q[i] != tgt_q[i]) all_eq = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        fan_d   = fan_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                // A handshake outranks a timeout expiring in the same cycle.
                if (i_angle_valid) begin
                    angle_d = (i_angle >= NO_OBST) ? NO_OBST : i_angle;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (i_tick) begin
                    if (cnt_q + 16'd1 == TIMEOUT_LIM) begin
                        cnt_d   = '0;
                        angle_d = NO_OBST;
                        state_d = SETTLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            SETTLE: begin
                cnt_d   = '0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                for (int i = 0; i < 6; i++) tgt_d[i] = clamp_pct(proc_fan[i]);
                cnt_d   = '0;
                state_d = RAMP;
            end
            RAMP: begin
                if (i_tick) begin
                    for (int i = 0; i < 6; i++) fan_d[i] = ramp_toward(fan_q[i], tgt_q[i]);
                end
                cnt_d = '0;
                if (all_eq) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            angle_q <= NO_OBST;
            for (int i = 0; i < 6; i++) begin
                fan_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            fan_q   <= fan_d;
            tgt_q   <= tgt_d;
        end
    end

    assign o_angle_ready = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_proc_angle  = angle_q;
    assign o_fan_1       = fan_q[0];
    assign o_fan_2       = fan_q[1];
    assign o_fan_3       = fan_q[2];
    assign o_fan_4       = fan_q[3];
    assign o_fan_5       = fan_q[4];
    assign o_fan_6       = fan_q[5];

endmodule

// File: doc/slipstream_scheduler.md
SLIPSTREAM_SCHEDULER -- requirements
Module: slipstream_scheduler

Interface
REQ-001 RAMP_STEP, 5, maximum change in fan percent per i_tick (1..100).
REQ-002 TIMEOUT_TICKS, 200, i_tick count in IDLE without a new angle before obstruction clears (1..65535).
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_tick  in  1  single-cycle ramp/timeout strobe.
REQ-006 i_angle_valid  in  1  new obstruction angle offered.
REQ-007 i_angle  in  9  obstruction angle, 0-359; 360 or above means no obstruction.
REQ-008 o_angle_ready  out  1  scheduler accepts i_angle this cycle.
REQ-009 o_proc_angle  out  9  registered angle driven to the slipstream processor i_angle.
REQ-010 i_proc_fan_1..i_proc_fan_6  in  7 each  slipstream processor o_fan_1..o_fan_6 outputs.
REQ-011 o_fan_1..o_fan_6  out  7 each  slew-limited fan duty, percent 0-100.
REQ-012 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETTLE, CAPTURE and RAMP.
REQ-014 o_angle_ready SHALL be 1 exactly when state is IDLE; handshake = i_angle_valid & o_angle_ready.
REQ-015 On handshake, o_proc_angle SHALL load i_angle (values 360-511 loaded as 360) and state SHALL go to SETTLE.
REQ-016 SETTLE SHALL last exactly one cycle, then go to CAPTURE (processor outputs settle for a full cycle).
REQ-017 In CAPTURE, target_n SHALL register min(i_proc_fan_n, 100) for all six fans in the same cycle, then go to RAMP.
REQ-018 In RAMP, on each i_tick, each o_fan_n SHALL move toward target_n by min(RAMP_STEP, |target_n - o_fan_n|); no overshoot; 8-bit intermediate arithmetic, no wrap.
REQ-019 RAMP SHALL go to IDLE in the cycle after all six o_fan_n equal their target_n, evaluated every cycle whether or not i_tick is high; equal at entry means one RAMP cycle.
REQ-020 i_tick SHALL be ignored in SETTLE and CAPTURE; o_fan_n SHALL hold in every state except RAMP.
REQ-021 In IDLE, a 16-bit timeout counter SHALL increment on each i_tick; on reaching TIMEOUT_TICKS it SHALL clear, o_proc_angle SHALL load 360, and state SHALL go to SETTLE.
REQ-022 The timeout counter SHALL clear on every handshake and on leaving IDLE for any reason.
REQ-023 A handshake and timeout expiry in the same cycle SHALL take the handshake: i_angle is loaded and the counter clears.
REQ-024 The timeout SHALL still fire when o_proc_angle is already 360; this re-capture is harmless.
REQ-025 i_angle_valid outside IDLE SHALL be ignored, with no latching and no queueing.

Reset
REQ-026 While i_rst_n=0: state=IDLE, o_proc_angle=360, o_fan_1..6=0, target_1..6=0, timeout counter=0, o_busy=0.
REQ-027 Assertion mid-operation (any state) SHALL abort immediately to REQ-026 values; the first handshake is possible on the first edge after deassertion.

Verification
REQ-028 Processor demand 100 on all fans, reset released, angle 30 offered -> o_busy rises; at CAPTURE targets are 0,50,100,100,100,50; after 10 ticks o_fan_2=o_fan_6=50; after 20 ticks o_fan_3..5=100 and o_fan_1=0; o_busy falls one cycle later.
REQ-029 From steady angle 30, offer angle 60 -> targets 13,100,100,100,100,13; o_fan_1 reaches 13 after 3 ticks (5,10,13); o_fan_6 reaches 13 after 8 ticks (45,40,...,15,13), with no overshoot.
REQ-030 TIMEOUT_TICKS=4, steady at angle 90, no valid -> after the 4th i_tick, o_proc_angle=360; all outputs ramp to 100; counter restarts.
REQ-031 i_angle_valid held high during RAMP with angle 150 -> not accepted until IDLE; accepted on the first IDLE cycle.
REQ-032 Angle 400 offered -> o_proc_angle=360.
REQ-033 i_rst_n pulsed low mid-RAMP with o_fan_3=40 -> all o_fan=0, o_proc_angle=360 asynchronously; o_angle_ready=1 after release.
